// File: rtl/seg_tick_counter.sv
// seg_tick_counter
//   Counts rising edges of the divided clock from the divider/timer block in a
//   4-digit BCD counter and shows the count on a multiplexed, active-low
//   4-digit 7-segment display.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   -> leading zero digits (3..1) are blanked, units always shown
//     undefined -> all four digits always decoded
//
// Parameters
//   SCAN_DIV   clk cycles each digit stays lit (>= 2)
//   SCAN_W     scan prescaler width, 2^SCAN_W >= SCAN_DIV
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   tick_in    divided clock, asynchronous to clk
//   clr        synchronous clear of count and ovf (level)
//   hold       freeze counting; pulses seen while high are dropped
//   count_bcd  {d3,d2,d1,d0} BCD count, d0 = units (registered)
//   ovf        sticky wrap flag, set on 9999 -> 0000 (registered)
//   an         active-low one-hot digit enables, an[0] = units (registered)
//   seg        active-low segments {g,f,e,d,c,b,a} (registered)

module seg_tick_counter #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned SCAN_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        clr,
   input  logic        hold,
   output logic [15:0] count_bcd,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   logic              s1, s2, s3;
   logic              pulse;
   logic [15:0]       count_inc;
   logic              inc_carry;
   logic [SCAN_W-1:0] presc;
   logic [1:0]        idx;
   logic [3:0]        digit;
   logic [6:0]        seg_dec;
   logic              blank;

   // s1/s2 resolve metastability; s3 is the previous s2 for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tick_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;

   // Ripple BCD increment: a digit at 9 (or any out-of-range code) rolls to 0
   // and passes the carry on; carry out of d3 marks the 9999 -> 0000 wrap.
   always_comb begin
      count_inc = count_bcd;
      inc_carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (inc_carry) begin
            if (count_bcd[4*i +: 4] >= 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
               inc_carry           = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_bcd <= '0;
         ovf       <= 1'b0;
      end else if (!hold && pulse) begin
         count_bcd <= count_inc;
         if (inc_carry) begin
            ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == SCAN_W'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + SCAN_W'(1);
      end
   end

   always_comb begin
      digit = 4'd0;
      case (idx)
         2'd0: digit = count_bcd[3:0];
         2'd1: digit = count_bcd[7:4];
         2'd2: digit = count_bcd[11:8];
         2'd3: digit = count_bcd[15:12];
         default: digit = 4'd0;
      endcase
   end

   always_comb begin
      seg_dec = 7'b1111111;
      case (digit)
         4'd0: seg_dec = 7'b1000000;
         4'd1: seg_dec = 7'b1111001;
         4'd2: seg_dec = 7'b0100100;
         4'd3: seg_dec = 7'b0110000;
         4'd4: seg_dec = 7'b0011001;
         4'd5: seg_dec = 7'b0010010;
         4'd6: seg_dec = 7'b0000010;
         4'd7: seg_dec = 7'b1111000;
         4'd8: seg_dec = 7'b0000000;
         4'd9: seg_dec = 7'b0010000;
         default: seg_dec = 7'b1111111;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blank when it and every more significant digit is zero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd3: blank = (count_bcd[15:12] == 4'd0);
         2'd2: blank = (count_bcd[15:8] == 8'd0);
         2'd1: blank = (count_bcd[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase
   end
`else
   always_comb begin
      blank = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= '1;
         seg <= '1;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= blank ? 7'b1111111 : seg_dec;
      end
   end

endmodule
